// File: rtl/riscv_core_if.sv
// Preload / debug port bundle of the single-cycle core.
interface riscv_core_if;
  logic        enable_load_ex_mem;
  logic        enable_halt;
  logic [8:0]  DataExMemAddress;
  logic [31:0] DataExMemData1;
  logic [31:0] DataExMemData2;
  logic [8:0]  InstExMemAddress;
  logic [31:0] InstExMemData1;
  logic [31:0] InstExMemData2;
  logic [4:0]  DebugSel;
  logic [31:0] DebugOutput;

  modport master (
    output enable_load_ex_mem, enable_halt,
    output DataExMemAddress, DataExMemData1, DataExMemData2,
    output InstExMemAddress, InstExMemData1, InstExMemData2,
    output DebugSel,
    input  DebugOutput
  );

  modport slave (
    input  enable_load_ex_mem, enable_halt,
    input  DataExMemAddress, DataExMemData1, DataExMemData2,
    input  InstExMemAddress, InstExMemData1, InstExMemData2,
    input  DebugSel,
    output DebugOutput
  );
endinterface

// File: rtl/riscv_core.sv
// Single-cycle RV32I subset core with word-indexed instruction/data memories
// that can be preloaded two words per clock from outside.
module riscv_core #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 512
) (
  input logic         clk,
  input logic         reset,
  riscv_core_if.slave bus
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_LD  = 7'b0000011, OP_ST  = 7'b0100011, OP_BR  = 7'b1100011,
                         OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];
  logic [31:0] rf_q   [32];
  logic [31:0] pc_q, pc_d;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1v, rs2v, imm_i, imm_s, imm_b, imm_j, imm_u, pc4;
  logic [DAW-1:0] ld_idx, st_idx;
  logic        rd_we, dm_we;
  logic [31:0] rd_wdata;
  logic        run;

  assign instr = imem_q[pc_q[IAW+1:2]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  assign rs1v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign pc4  = pc_q + 32'd4;

  // Only the low address bits matter: the data memory wraps on its word index.
  assign ld_idx = rs1v[DAW-1:0] + imm_i[DAW-1:0];
  assign st_idx = rs1v[DAW-1:0] + imm_s[DAW-1:0];

  assign run = !bus.enable_load_ex_mem && !bus.enable_halt;

  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = 32'd0;
    dm_we    = 1'b0;
    pc_d     = pc4;
    unique case (opc)
      OP_LUI: begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_IMM: begin
        rd_we = 1'b1;
        case (f3)
          3'b000:  rd_wdata = rs1v + imm_i;
          3'b111:  rd_wdata = rs1v & imm_i;
          3'b110:  rd_wdata = rs1v | imm_i;
          3'b100:  rd_wdata = rs1v ^ imm_i;
          3'b010:  rd_wdata = {31'd0, $signed(rs1v) < $signed(imm_i)};
          default: rd_we = 1'b0;
        endcase
      end
      OP_REG: begin
        rd_we = 1'b1;
        case ({f7, f3})
          10'b0000000_000: rd_wdata = rs1v + rs2v;
          10'b0100000_000: rd_wdata = rs1v - rs2v;
          10'b0000000_111: rd_wdata = rs1v & rs2v;
          10'b0000000_110: rd_wdata = rs1v | rs2v;
          10'b0000000_100: rd_wdata = rs1v ^ rs2v;
          10'b0000000_010: rd_wdata = {31'd0, $signed(rs1v) < $signed(rs2v)};
          10'b0000000_001: rd_wdata = rs1v << rs2v[4:0];
          10'b0000000_101: rd_wdata = rs1v >> rs2v[4:0];
          10'b0100000_101: rd_wdata = 32'($signed(rs1v) >>> rs2v[4:0]);
          default:         rd_we = 1'b0;
        endcase
      end
      // Memory is word-only, so the width field of loads/stores is ignored.
      OP_LD: begin rd_we = 1'b1; rd_wdata = dmem_q[ld_idx]; end
      OP_ST: dm_we = 1'b1;
      OP_BR: begin
        case (f3)
          3'b000:  if (rs1v == rs2v) pc_d = pc_q + imm_b;
          3'b001:  if (rs1v != rs2v) pc_d = pc_q + imm_b;
          3'b100:  if ($signed(rs1v) <  $signed(rs2v)) pc_d = pc_q + imm_b;
          3'b101:  if ($signed(rs1v) >= $signed(rs2v)) pc_d = pc_q + imm_b;
          default: pc_d = pc4;
        endcase
      end
      OP_JAL: begin rd_we = 1'b1; rd_wdata = pc4; pc_d = pc_q + imm_j; end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          rd_we    = 1'b1;
          rd_wdata = pc4;
          pc_d     = (rs1v + imm_i) & ~32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (run) begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_wdata;
    end
  end

  logic [IAW-1:0] ia0, ia1;
  logic [DAW-1:0] da0, da1;
  assign ia0 = bus.InstExMemAddress[IAW-1:0];
  assign ia1 = ia0 + IAW'(1);
  assign da0 = bus.DataExMemAddress[DAW-1:0];
  assign da1 = da0 + DAW'(1);

  // Preload ignores reset; program stores are blocked by reset, preload or halt.
  always_ff @(posedge clk) begin
    if (bus.enable_load_ex_mem) begin
      imem_q[ia0] <= bus.InstExMemData1;
      imem_q[ia1] <= bus.InstExMemData2;
      dmem_q[da0] <= bus.DataExMemData1;
      dmem_q[da1] <= bus.DataExMemData2;
    end else if (!reset && !bus.enable_halt && dm_we) begin
      dmem_q[st_idx] <= rs2v;
    end
  end

  assign bus.DebugOutput = (bus.DebugSel == 5'd0) ? 32'd0 : rf_q[bus.DebugSel];
endmodule

// File: tb/tb_riscv_core.sv
// Bench for riscv_core: preloads small programs, runs them, and checks the
// register file through the debug port against a queue of expected values.
module tb_riscv_core;
  logic clk = 1'b0;
  logic reset;
  riscv_core_if bus ();

  riscv_core #(.IMEM_WORDS(512), .DMEM_WORDS(512)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { string name; logic [4:0] sel; logic [31:0] exp; } sb_t;
  typedef struct { string name; logic [31:0] ins; logic [31:0] exp; } vec_t;

  sb_t  sb[$];
  vec_t vt[$];
  logic [31:0] prog[$];
  int n_chk = 0, n_pass = 0;

  localparam logic [6:0] OPI = 7'b0010011, OPL = 7'b0000011, OPJR = 7'b1100111;

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] ia, input logic [31:0] i1, input logic [31:0] i2,
                      input logic [8:0] da, input logic [31:0] d1, input logic [31:0] d2,
                      input int cycles);
    bus.InstExMemAddress = ia; bus.InstExMemData1 = i1; bus.InstExMemData2 = i2;
    bus.DataExMemAddress = da; bus.DataExMemData1 = d1; bus.DataExMemData2 = d2;
    bus.enable_load_ex_mem = 1'b1;
    repeat (cycles) tick();
    bus.enable_load_ex_mem = 1'b0;
  endtask

  // Instruction pairs go to imem from 0; the paired dmem writes land in a scratch area.
  task automatic load_prog();
    for (int i = 0; i < prog.size(); i += 2)
      load(9'(i), prog[i], (i + 1 < prog.size()) ? prog[i+1] : 32'd0,
           9'd400, 32'd0, 32'd0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    bus.enable_halt = 1'b0;
    repeat (n) tick();
    bus.enable_halt = 1'b1;
  endtask

  task automatic expect_reg(input string name, input logic [4:0] sel, input logic [31:0] exp);
    sb.push_back('{name, sel, exp});
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      bus.DebugSel = e.sel;
      #1;
      n_chk++;
      if (bus.DebugOutput === e.exp) n_pass++;
      else $display("FAIL %s: x%0d got %h expected %h", e.name, e.sel, bus.DebugOutput, e.exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.enable_load_ex_mem = 1'b0;
    bus.enable_halt = 1'b1;
    bus.DebugSel = 5'd0;
    bus.InstExMemAddress = '0; bus.InstExMemData1 = '0; bus.InstExMemData2 = '0;
    bus.DataExMemAddress = '0; bus.DataExMemData1 = '0; bus.DataExMemData2 = '0;
    tick();

    // Reset state
    do_reset();
    expect_reg("rst_x1", 5'd1, 32'd0);
    expect_reg("rst_x31", 5'd31, 32'd0);
    expect_reg("rst_x0", 5'd0, 32'd0);
    drain();

    // ALU vectors: x1=-7, x2=3, result in x3
    vt.push_back('{"add",  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFFC});
    vt.push_back('{"sub",  enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 32'hFFFF_FFF6});
    vt.push_back('{"and",  enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 32'h0000_0001});
    vt.push_back('{"or",   enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 32'hFFFF_FFFB});
    vt.push_back('{"xor",  enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 32'hFFFF_FFFA});
    vt.push_back('{"slt",  enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd3), 32'h0000_0001});
    vt.push_back('{"sll",  enc_r(7'h00, 5'd2, 5'd1, 3'b001, 5'd3), 32'hFFFF_FFC8});
    vt.push_back('{"sll5", enc_r(7'h00, 5'd1, 5'd2, 3'b001, 5'd3), 32'h0600_0000});
    vt.push_back('{"srl",  enc_r(7'h00, 5'd2, 5'd1, 3'b101, 5'd3), 32'h1FFF_FFFF});
    vt.push_back('{"sra",  enc_r(7'h20, 5'd2, 5'd1, 3'b101, 5'd3), 32'hFFFF_FFFF});
    vt.push_back('{"addi", enc_i(12'd100, 5'd1, 3'b000, 5'd3, OPI), 32'h0000_005D});
    vt.push_back('{"andi", enc_i(12'h0F0, 5'd1, 3'b111, 5'd3, OPI), 32'h0000_00F0});
    vt.push_back('{"ori",  enc_i(12'hF00, 5'd2, 3'b110, 5'd3, OPI), 32'hFFFF_FF03});
    vt.push_back('{"xori", enc_i(12'hFFF, 5'd1, 3'b100, 5'd3, OPI), 32'h0000_0006});
    vt.push_back('{"slti", enc_i(12'h000, 5'd1, 3'b010, 5'd3, OPI), 32'h0000_0001});
    vt.push_back('{"sltin", enc_i(12'hFF8, 5'd1, 3'b010, 5'd3, OPI), 32'h0000_0000});
    vt.push_back('{"lui",  {20'hABCDE, 5'd3, 7'b0110111}, 32'hABCD_E000});
    vt.push_back('{"nop_sltiu", enc_i(12'd5, 5'd2, 3'b011, 5'd3, OPI), 32'h0000_0000});
    vt.push_back('{"nop_zero", 32'h0000_0000, 32'h0000_0000});
    foreach (vt[k]) begin
      prog = '{enc_i(12'hFF9, 5'd0, 3'b000, 5'd1, OPI), enc_i(12'd3, 5'd0, 3'b000, 5'd2, OPI),
               vt[k].ins, 32'd0};
      load_prog();
      do_reset();
      run(3);
      expect_reg(vt[k].name, 5'd3, vt[k].exp);
      drain();
    end

    // Basic program: addi x7,x0,1 ; lw x6,0(x7)
    load(9'd0, 32'h0010_0393, 32'h0003_8303, 9'd0, 32'h0000_8F00, 32'h0000_00FF, 1);
    do_reset();
    run(2);
    expect_reg("basic_x7", 5'd7, 32'd1);
    expect_reg("basic_x6", 5'd6, 32'h0000_00FF);
    drain();

    // Reset clears registers; memories survive and the rerun matches
    do_reset();
    for (int r = 0; r < 32; r++) expect_reg("rst_clear", 5'(r), 32'd0);
    drain();
    run(2);
    expect_reg("rerun_x7", 5'd7, 32'd1);
    expect_reg("rerun_x6", 5'd6, 32'h0000_00FF);
    drain();

    // Halt right after reset, then release
    do_reset();
    repeat (3) tick();
    expect_reg("halt_x7", 5'd7, 32'd0);
    drain();
    run(2);
    expect_reg("unhalt_x7", 5'd7, 32'd1);
    expect_reg("unhalt_x6", 5'd6, 32'h0000_00FF);
    drain();

    // Preload freezes the core even with halt released
    do_reset();
    bus.enable_halt = 1'b0;
    load(9'd20, 32'd0, 32'd0, 9'd300, 32'd0, 32'd0, 3);
    bus.enable_halt = 1'b1;
    expect_reg("ldfrz_x7", 5'd7, 32'd0);
    drain();
    run(1);
    expect_reg("ldfrz_run_x7", 5'd7, 32'd1);
    expect_reg("ldfrz_run_x6", 5'd6, 32'd0);
    drain();

    // Reset on the store's edge aborts the store
    load(9'd0, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), enc_s(12'd3, 5'd1, 5'd0),
         9'd2, 32'd0, 32'h0000_AAAA, 1);
    do_reset();
    run(1);
    bus.enable_halt = 1'b0;
    do_reset();
    bus.enable_halt = 1'b1;
    load(9'd0, enc_i(12'd3, 5'd0, 3'b010, 5'd2, OPL), 32'd0, 9'd100, 32'd0, 32'd0, 1);
    do_reset();
    run(1);
    expect_reg("rst_abort_sw", 5'd2, 32'h0000_AAAA);
    drain();

    // Store/load round trip and x0 write ignored
    prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI), enc_s(12'd3, 5'd1, 5'd0),
             enc_i(12'd3, 5'd0, 3'b010, 5'd2, OPL), enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPI)};
    load_prog();
    do_reset();
    run(4);
    expect_reg("swlw_x2", 5'd2, 32'd5);
    expect_reg("swlw_x1", 5'd1, 32'd5);
    expect_reg("x0_write", 5'd0, 32'd0);
    drain();

    // beq skip
    prog = '{enc_b(13'd8, 5'd0, 5'd0, 3'b000), enc_i(12'd1, 5'd0, 3'b000, 5'd10, OPI),
             enc_i(12'd2, 5'd0, 3'b000, 5'd11, OPI), 32'd0};
    load_prog();
    do_reset();
    run(2);
    expect_reg("beq_skip_x10", 5'd10, 32'd0);
    expect_reg("beq_tgt_x11", 5'd11, 32'd2);
    drain();

    // Branches and jumps
    prog = '{enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, OPI),
             enc_b(13'd8, 5'd0, 5'd1, 3'b001),
             enc_i(12'd1, 5'd0, 3'b000, 5'd12, OPI),
             enc_b(13'd8, 5'd0, 5'd1, 3'b100),
             enc_i(12'd1, 5'd0, 3'b000, 5'd13, OPI),
             enc_b(13'd8, 5'd0, 5'd1, 3'b101),
             enc_i(12'd7, 5'd0, 3'b000, 5'd14, OPI),
             enc_j(21'd8, 5'd15),
             enc_i(12'd1, 5'd0, 3'b000, 5'd16, OPI),
             enc_i(12'd45, 5'd0, 3'b000, 5'd17, OPJR),
             enc_i(12'd1, 5'd0, 3'b000, 5'd18, OPI),
             enc_i(12'd3, 5'd0, 3'b000, 5'd19, OPI)};
    load_prog();
    do_reset();
    run(8);
    expect_reg("bne_skip", 5'd12, 32'd0);
    expect_reg("blt_skip", 5'd13, 32'd0);
    expect_reg("bge_fall", 5'd14, 32'd7);
    expect_reg("jal_link", 5'd15, 32'd32);
    expect_reg("jal_skip", 5'd16, 32'd0);
    expect_reg("jalr_link", 5'd17, 32'd40);
    expect_reg("jalr_skip", 5'd18, 32'd0);
    expect_reg("jalr_tgt", 5'd19, 32'd3);
    drain();

    // Preload address wrap at 511, plus PC wrap through imem[511]
    load(9'd511, enc_i(12'd11, 5'd0, 3'b000, 5'd5, OPI), enc_i(12'd22, 5'd0, 3'b000, 5'd4, OPI),
         9'd511, 32'h0000_1234, 32'h0000_5678, 1);
    load(9'd1, enc_i(12'd511, 5'd0, 3'b010, 5'd8, OPL), enc_i(12'd0, 5'd0, 3'b010, 5'd9, OPL),
         9'd100, 32'd0, 32'd0, 1);
    load(9'd3, enc_i(12'd2044, 5'd0, 3'b000, 5'd0, OPJR), 32'd0, 9'd100, 32'd0, 32'd0, 1);
    do_reset();
    run(5);
    expect_reg("wrap_imem0", 5'd4, 32'd22);
    expect_reg("wrap_dmem511", 5'd8, 32'h0000_1234);
    expect_reg("wrap_dmem0", 5'd9, 32'h0000_5678);
    expect_reg("wrap_imem511", 5'd5, 32'd11);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_core.md
RISCV_CORE -- requirements
Module: riscv_core

Interface
REQ-001 Parameter IMEM_WORDS, 512, instruction memory depth in 32-bit words (9-bit word index).
REQ-002 Parameter DMEM_WORDS, 512, data memory depth in 32-bit words (9-bit word index).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable_load_ex_mem  in  1  external memory preload enable.
REQ-006 enable_halt  in  1  freeze core execution while high.
REQ-007 DataExMemAddress  in  9  data memory preload word address.
REQ-008 DataExMemData1  in  32  word written to data mem [DataExMemAddress].
REQ-009 DataExMemData2  in  32  word written to data mem [DataExMemAddress+1].
REQ-010 InstExMemAddress  in  9  instruction memory preload word address.
REQ-011 InstExMemData1  in  32  word written to inst mem [InstExMemAddress].
REQ-012 InstExMemData2  in  32  word written to inst mem [InstExMemAddress+1].
REQ-013 DebugSel  in  5  register file index to observe.
REQ-014 DebugOutput  out  32  combinational read of x[DebugSel]; 0 when DebugSel=0.

Function
REQ-015 Core SHALL be a single-cycle RV32I subset: one instruction retires per enabled clock.
REQ-016 Supported: LUI, ADDI, ANDI, ORI, XORI, SLTI, ADD, SUB, AND, OR, XOR, SLT, SLL, SRL, SRA, LW, SW, BEQ, BNE, BLT, BGE, JAL, JALR.
REQ-017 Any other encoding (incl. 0x00000000) SHALL execute as NOP: PC+4, no register/memory write.
REQ-018 PC is a 32-bit byte address; fetch word = imem[PC[10:2]]; PC wraps modulo memory size.
REQ-019 Data memory SHALL be word-indexed: LW/SW use effective address (rs1+imm)[8:0] as word index, wrapping modulo 512.
REQ-020 Register file: 32x32; x0 reads 0; writes to x0 ignored; write occurs on the rising edge ending the instruction.
REQ-021 Branch/JAL targets SHALL be PC+imm (byte offset); JALR target (rs1+imm)&~1; link = PC+4.
REQ-022 Arithmetic SHALL be 32-bit modulo 2^32; SLT signed; shifts use low 5 bits.
REQ-023 When enable_load_ex_mem=1, each rising edge SHALL write both pairs (Data1 at addr, Data2 at addr+1 mod 512) into both memories, regardless of reset.
REQ-024 When enable_load_ex_mem=1, PC, register file and program-initiated memory writes SHALL be frozen.
REQ-025 When enable_halt=1 (and not reset), PC, register file and data memory SHALL hold; DebugOutput stays valid.
REQ-026 Priority per edge: reset > enable_load_ex_mem (core frozen, load proceeds) > enable_halt > normal execution.
REQ-027 Memories SHALL be retained across reset; power-up contents undefined.

Reset
REQ-028 reset=1 at a rising edge SHALL set PC=0 and all registers x1..x31=0; DebugOutput reads 0 the next cycle.
REQ-029 Reset mid-execution SHALL abort the current instruction (no register/memory write that edge).
REQ-030 First instruction executed after reset deasserts is imem[0].

Verification
REQ-031 Preload imem[0]=0x00100393 (addi x7,x0,1), imem[1]=0x00038303 (lw x6,0(x7)), dmem[0]=0x00008F00, dmem[1]=0x000000FF; reset; run 2 cycles -> DebugSel=7 gives 1, DebugSel=6 gives 0x000000FF.
REQ-032 Same program, enable_halt=1 before first edge after reset for 3 cycles -> DebugSel=7 stays 0; after release, results as REQ-031 two cycles later.
REQ-033 Run program, then pulse reset -> all DebugSel reads 0; rerun without preload -> same results (memory retained).
REQ-034 addi x1,x0,5; sw x1,3(x0); lw x2,3(x0) -> x2=5; addi x0,x0,9 -> DebugSel=0 reads 0.
REQ-035 beq x0,x0,+8 at PC=0 -> instruction at PC=4 skipped (its destination register remains 0), PC=8 executes.
REQ-036 Preload with InstExMemAddress=511 -> Data1 at 511, Data2 at 0 (wrap).
